// File: rtl/fmad_issue.sv
// fmad_issue: requester front end for the 3-stage single-precision FMA pipeline.
// Ports:
//   clk, reset            clock, synchronous active-high reset (shared with the FMA pipeline)
//   in_valid/in_ready     command handshake; in_x/in_y/in_z operands, in_tag opaque tag
//   fmad_req              one-cycle request pulse; fmad_x/y/z registered operands, held 2 cycles
//   fmad_rslt/fmad_flag   pipeline result and {NV,DZ,OF,UF,NX}, valid 4 cycles after fmad_req
//   out_valid/out_ready   result handshake; out_rslt/out_flag/out_tag from the FIFO head
//   busy                  any op issuing, in flight or buffered
module fmad_issue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [31:0]     in_y,
  input  logic [31:0]     in_z,
  input  logic [TAGW-1:0] in_tag,
  output logic            fmad_req,
  output logic [31:0]     fmad_x,
  output logic [31:0]     fmad_y,
  output logic [31:0]     fmad_z,
  input  logic [31:0]     fmad_rslt,
  input  logic [4:0]      fmad_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_rslt,
  output logic [4:0]      out_flag,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t          state;
  logic [TAGW-1:0] tag;
  logic [3:0]      pv;
  logic [TAGW-1:0] pt [4];
  logic [CW-1:0]   inflight, count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem_r [DEPTH];
  logic [4:0]      mem_f [DEPTH];
  logic [TAGW-1:0] mem_t [DEPTH];
  logic            credit_ok, accept, wr, pop;
  // Credits cover both in-flight and buffered ops, so every pipeline result
  // always has a FIFO slot waiting for it.
  assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(DEPTH);
  assign in_ready  = !reset && state != ISSUE && credit_ok;
  assign accept    = in_valid && in_ready;
  assign wr        = pv[3];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign out_rslt  = mem_r[rd_ptr];
  assign out_flag  = mem_f[rd_ptr];
  assign out_tag   = mem_t[rd_ptr];
  assign busy      = state != IDLE || inflight != '0 || count != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fmad_req <= 1'b0;
      fmad_x   <= '0;
      fmad_y   <= '0;
      fmad_z   <= '0;
      tag      <= '0;
      pv       <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= accept ? ISSUE : state == ISSUE ? HOLD : IDLE;
      fmad_req <= accept;
      if (accept) begin
        fmad_x <= in_x;
        fmad_y <= in_y;
        fmad_z <= in_z;
        tag    <= in_tag;
      end
      pv       <= {pv[2:0], fmad_req};
      inflight <= inflight + CW'(accept) - CW'(wr);
      count    <= count + CW'(wr) - CW'(pop);
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  // Data-only storage: validity lives in pv/count, which reset clears, so stale
  // entries written here can never become visible.
  always_ff @(posedge clk) begin
    pt[0] <= tag;
    pt[1] <= pt[0];
    pt[2] <= pt[1];
    pt[3] <= pt[2];
    if (wr) begin
      mem_r[wr_ptr] <= fmad_rslt;
      mem_f[wr_ptr] <= fmad_flag;
      mem_t[wr_ptr] <= pt[3];
    end
  end
endmodule

// File: doc/fmad_issue.md
Name: fmad_issue

Overview:
- Requester-side front end for the 3-stage single-precision FMA pipeline: accepts tagged x*y+z commands on a valid/ready interface and drives the pipeline's req/operand interface with the required timing.
- Tracks in-flight operations with a tag/valid shift pipe, captures each result and flag set at the fixed pipeline latency, and buffers them in an in-order result FIFO with valid/ready backpressure.
- Sits between the instruction/operand sequencer and the FMA datapath.

Parameters:
DEPTH, 4, result FIFO entries; also the cap on in-flight plus buffered ops (power of 2, 2..16)
TAGW, 4, width of the opaque command tag carried with each op

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  command present
in_ready  out  1  command accepted when in_valid&in_ready at clk edge
in_x  in  32  multiplicand (IEEE-754 single)
in_y  in  32  multiplier
in_z  in  32  addend
in_tag  in  TAGW  command tag, returned with result
fmad_req  out  1  one-cycle request pulse to FMA pipeline
fmad_x  out  32  operand x to pipeline
fmad_y  out  32  operand y to pipeline
fmad_z  out  32  operand z to pipeline
fmad_rslt  in  32  pipeline result
fmad_flag  in  5  pipeline flags {NV,DZ,OF,UF,NX}, bit4..bit0
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid&out_ready at clk edge
out_rslt  out  32  result
out_flag  out  5  flags
out_tag  out  TAGW  tag of this result
busy  out  1  any op in flight or buffered

Behaviour:
- Reset: FSM->IDLE; fmad_req=0; fmad_x/y/z=0; pipe valids cleared; FIFO empty; out_valid=0; busy=0; in_ready=0 during reset cycle. fmad pipeline shares this reset; reset mid-operation discards all in-flight and buffered results, no late result is ever written.
- Operand timing: pipeline samples operands in the req cycle and the following cycle; fmad_x/y/z are registers loaded only on command acceptance and held at least 2 cycles (req cycle + hold cycle).
- FSM states IDLE, ISSUE, HOLD:
  - IDLE: in_ready=credit_ok. Accept -> load operands/tag, go ISSUE.
  - ISSUE: fmad_req=1, in_ready=0; go HOLD.
  - HOLD: in_ready=credit_ok. Accept -> reload operands, go ISSUE; else go IDLE.
- Max throughput one command per 2 cycles. Accept at cycle t -> fmad_req at t+1.
- Credits: credit_ok = (inflight + fifo_count) < DEPTH. inflight increments at acceptance, decrements at FIFO write. The FIFO therefore never overflows and a result is never dropped or stalled (pipeline has no backpressure).
- Result capture: 4-deep valid/tag shift pipe advanced every cycle, loaded with req. Req at t+1 -> fmad_rslt/fmad_flag valid in cycle t+5 -> written into FIFO at end of t+5 -> out_valid earliest at t+6 (end-to-end latency 6 cycles, FIFO empty).
- FIFO: in order, out_* driven from head register; simultaneous write and pop in the same cycle allowed when full or empty (count unchanged when both occur). Pop on empty is ignored.
- busy = (FSM!=IDLE) | inflight!=0 | fifo_count!=0.
- Results, flags and tags pass through unmodified; no arithmetic performed here. Counters are ceil(log2(DEPTH+1)) bits wide, no wrap possible by construction; FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single op x=0x3f800000, y=0x40000000, z=0x40400000, tag=5 accepted at t -> fmad_req pulse at t+1 only, operands stable t+1..t+2, out_valid at t+6 with out_rslt=0x40a00000, out_flag=0, out_tag=5.
- in_valid held high with out_ready=1, 6 commands tags 0..5 -> in_ready pattern 1,0,1,0,...; fmad_req every 2nd cycle; results emerge in tag order 0..5, one per 2 cycles.
- out_ready=0, DEPTH=4: after 4 accepts in_ready stays 0 indefinitely; FIFO holds 4 entries; raising out_ready one cycle -> one pop, in_ready reasserts next IDLE/HOLD cycle.
- Full FIFO with simultaneous pop and result write -> count stays DEPTH, no entry lost or duplicated (check tag sequence).
- Pipeline flag passthrough: x=0x7f800000, y=0x00000000, z=0 -> out_rslt=0xffc00000, out_flag=5'h10.
- Assert reset for 1 cycle while 2 ops in flight and 1 buffered -> out_valid=0, busy=0 next cycle; no result appears in following 10 cycles; next command completes normally at t+6.
